// File: rtl/restoring_divider8.sv
// Restoring unsigned divider: one quotient bit per clock, MSB first.
// start is sampled when ready=1; done pulses once, WIDTH+1 cycles after the
// start edge. Optional reconstruction check (quotient*divisor+remainder ==
// dividend) is built only when DIVIDER_SELFCHECK_EN is defined; otherwise
// check_err is tied low and no check logic exists.
module restoring_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             check_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Working registers. dvd_q shifts dividend bits out at the top and
  // quotient bits in at the bottom, so it ends up holding the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Result registers, held until the next DONE entry.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

`ifdef DIVIDER_SELFCHECK_EN
  logic [WIDTH-1:0]   orig_q, orig_d;
  logic               chk_q, chk_d;
  logic [2*WIDTH-1:0] recon;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The extra top bit makes the borrow exact even for full-scale operands.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             nonneg;
  logic             last_step;
  logic             accept;

  assign shifted   = {rem_q, dvd_q[WIDTH-1]};
  assign diff      = shifted - {2'b00, dsr_q};
  assign nonneg    = ~diff[WIDTH+1];
  assign last_step = (cnt_q == CW'(WIDTH));
  assign accept    = (state_q != RUN) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: RUN spans WIDTH iterations plus the result-latch cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, iterate in RUN, latch results
  // on the edge that enters DONE.
  always_comb begin
    dvd_d = dvd_q;
    dsr_d = dsr_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rmd_d = rmd_q;
    dbz_d = dbz_q;
`ifdef DIVIDER_SELFCHECK_EN
    orig_d = orig_q;
    chk_d  = chk_q;
    recon  = ({{WIDTH{1'b0}}, dvd_q} * {{WIDTH{1'b0}}, dsr_q})
           + {{WIDTH{1'b0}}, rem_q[WIDTH-1:0]};
`endif
    if (accept) begin
      dvd_d = dividend;
      dsr_d = divisor;
      rem_d = '0;
      cnt_d = '0;
`ifdef DIVIDER_SELFCHECK_EN
      orig_d = dividend;
`endif
    end else if (state_q == RUN) begin
      if (!last_step) begin
        rem_d = nonneg ? diff[WIDTH:0] : shifted[WIDTH:0];
        dvd_d = {dvd_q[WIDTH-2:0], nonneg};
        cnt_d = cnt_q + CW'(1);
      end else begin
        quo_d = dvd_q;
        rmd_d = rem_q[WIDTH-1:0];
        dbz_d = (dsr_q == '0);
`ifdef DIVIDER_SELFCHECK_EN
        chk_d = (dsr_q != '0) && (recon != {{WIDTH{1'b0}}, orig_q});
`endif
      end
    end
  end

  // Datapath registers; reset clears everything including held results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dsr_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= 1'b0;
`ifdef DIVIDER_SELFCHECK_EN
      orig_q <= '0;
      chk_q  <= 1'b0;
`endif
    end else begin
      dvd_q <= dvd_d;
      dsr_q <= dsr_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dbz_q <= dbz_d;
`ifdef DIVIDER_SELFCHECK_EN
      orig_q <= orig_d;
      chk_q  <= chk_d;
`endif
    end
  end

  assign ready       = (state_q != RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

`ifdef DIVIDER_SELFCHECK_EN
  assign check_err = chk_q;
`else
  assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider8.sv
// Scoreboard bench for restoring_divider8: stimulus pushes expected results,
// a monitor pops and compares on every done pulse (values and latency).
module tb_restoring_divider8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       ready, done, div_by_zero, check_err;
  logic [7:0] quotient, remainder;

  restoring_divider8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .ready(ready), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .check_err(check_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int dbz;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", int'(quotient), mon_e.q);
        chk("remainder", int'(remainder), mon_e.r);
        chk("div_by_zero", int'(div_by_zero), mon_e.dbz);
        chk("check_err", int'(check_err), 0);
        chk("latency", cyc, mon_e.at);
      end
    end
  end

  // Wait for ready, present one start for one cycle, optionally log expectation.
  task automatic issue(input int a, input int b, input int q, input int r,
                       input int dbz, input bit push);
    exp_t e;
    int   w = 0;
    while (!ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
    dividend = 8'(a);
    divisor  = 8'(b);
    start    = 1'b1;
    if (push) begin
      e.q = q; e.r = r; e.dbz = dbz;
      e.at = cyc + 1 + 9;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_outstanding", sb.size(), 0);
  endtask

  initial begin
    int a, b, nd;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    chk("rst_check_err", int'(check_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and boundary vectors, hand-computed.
    issue(200, 7, 28, 4, 0, 1);  drain();
    issue(255, 1, 255, 0, 0, 1); drain();
    issue(5, 9, 0, 5, 0, 1);     drain();
    issue(255, 255, 1, 0, 0, 1); drain();
    issue(0, 13, 0, 0, 0, 1);    drain();
    issue(100, 0, 255, 100, 1, 1); drain();
    chk("held_quotient", int'(quotient), 255);
    chk("held_dbz", int'(div_by_zero), 1);

    // start during RUN is ignored; operand changes after capture are harmless.
    issue(200, 7, 28, 4, 0, 1);
    repeat (3) @(negedge clk);
    chk("ready_in_run", int'(ready), 0);
    dividend = 8'd9; divisor = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 8'd77; divisor = 8'd2;
    // Waits for the DONE cycle, so this start is back-to-back.
    issue(9, 3, 3, 0, 0, 1);
    drain();

    // Reset in the 5th RUN cycle aborts with no done pulse afterwards.
    issue(100, 3, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    nd = done_seen;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_seen - nd, 0);

    // Random back-to-back operations against / and %.
    for (int i = 0; i < 2000; i++) begin
      a = $urandom_range(0, 255);
      b = (i % 16 == 0) ? 0 : $urandom_range(1, 255);
      if (b == 0) issue(a, b, 255, a, 1, 1);
      else        issue(a, b, a / b, a % b, 0, 1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
